aes_isub_ark: RTL and testbench

//  Inverse-cipher round front half: InvShiftRows, byte-serial InvSubBytes, then AddRoundKey.

---
 rtl/aes_isub_ark.sv | 119 +++++++++++
 tb/tb_aes_isub_ark.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_isub_ark.sv
// rtl/aes_isub_ark.sv - InvShiftRows, lane-serial InvSubBytes and AddRoundKey stage
module aes_isub_ark #(
  parameter  int LANES = 1,
  localparam int NB    = 4,
  localparam int BYTES = 4 * NB
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] INV_SBOX  [0:255],
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] state_in  [0:BYTES-1],
  input  logic [7:0] key_in    [0:BYTES-1],
  input  logic       last_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] state_out [0:BYTES-1],
  output logic       last_out
);

  localparam int N     = BYTES / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, SUB, DONE} fsm_t;

  fsm_t             state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [7:0]       state_buf_q [0:BYTES-1];
  logic [7:0]       state_buf_n [0:BYTES-1];
  logic [7:0]       key_q       [0:BYTES-1];
  logic [7:0]       key_n       [0:BYTES-1];
  logic [7:0]       shifted     [0:BYTES-1];
  logic [7:0]       sub_buf     [0:BYTES-1];
  logic             last_q, last_n;
  logic             capture;
  logic [IDX_W-1:0] byte_idx;

  // InvShiftRows is pure wiring: row r of column c comes from column (c - r) mod NB
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[4*c+r] = state_in[4*((c-r+NB)%NB)+r];
    end
  end

  // Substitute and key-mix the LANES bytes addressed by the current counter value
  always_comb begin
    sub_buf  = state_buf_q;
    byte_idx = '0;
    for (int j = 0; j < LANES; j++) begin
      byte_idx          = IDX_W'(int'(cnt_q) * LANES + j);
      sub_buf[byte_idx] = INV_SBOX[state_buf_q[byte_idx]] ^ key_q[byte_idx];
    end
  end

  // Next-state, handshake and capture decisions; DONE can accept a new block with no bubble
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    state_buf_n = state_buf_q;
    key_n       = key_q;
    last_n      = last_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        capture  = in_valid;
      end
      SUB: begin
        state_buf_n = sub_buf;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) capture = 1'b1;
          else          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (capture) begin
      state_buf_n = shifted;
      key_n       = key_in;
      last_n      = last_in;
      cnt_n       = '0;
      state_n     = SUB;
    end
  end

  // State, counter and data registers; reset drops any block in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      state_buf_q <= '{default: 8'h00};
      key_q       <= '{default: 8'h00};
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      state_buf_q <= state_buf_n;
      key_q       <= key_n;
      last_q      <= last_n;
    end
  end

  assign state_out = state_buf_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_aes_isub_ark.sv
// tb/tb_aes_isub_ark.sv - directed bench for aes_isub_ark at LANES=1 and LANES=4
module tb_aes_isub_ark;

  localparam logic [127:0] SBOX_ROWS [0:15] = '{
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] inv_sbox_tab [0:255];
  logic       in_valid;
  logic       last_in;
  logic [7:0] state_in [0:15];
  logic [7:0] key_in   [0:15];

  logic       in_ready1, out_valid1, out_ready1, last_out1;
  logic [7:0] state_out1 [0:15];
  logic       in_ready4, out_valid4, out_ready4, last_out4;
  logic [7:0] state_out4 [0:15];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  aes_isub_ark #(.LANES(1)) dut1 (
    .clock(clock), .reset(reset), .INV_SBOX(inv_sbox_tab),
    .in_valid(in_valid), .in_ready(in_ready1), .state_in(state_in), .key_in(key_in),
    .last_in(last_in), .out_valid(out_valid1), .out_ready(out_ready1),
    .state_out(state_out1), .last_out(last_out1)
  );

  aes_isub_ark #(.LANES(4)) dut4 (
    .clock(clock), .reset(reset), .INV_SBOX(inv_sbox_tab),
    .in_valid(in_valid), .in_ready(in_ready4), .state_in(state_in), .key_in(key_in),
    .last_in(last_in), .out_valid(out_valid4), .out_ready(out_ready4),
    .state_out(state_out4), .last_out(last_out4)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [7:0] a [0:15]);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = a[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [127:0] s, input logic [127:0] k, input logic l);
    for (int i = 0; i < 16; i++) begin
      state_in[i] = s[127-8*i -: 8];
      key_in[i]   = k[127-8*i -: 8];
    end
    last_in = l;
  endtask

  task automatic run_pair(input string tag, input logic [127:0] s, input logic [127:0] k,
                          input logic l, input logic [127:0] exp);
    int lat1;
    int lat4;
    int n;
    lat1 = 0;
    lat4 = 0;
    load(s, k, l);
    in_valid = 1'b1;
    check({tag, "_in_ready1"}, in_ready1, 1'b1);
    check({tag, "_in_ready4"}, in_ready4, 1'b1);
    step();
    in_valid = 1'b0;
    n = 1;
    check({tag, "_busy_in_ready1"}, in_ready1, 1'b0);
    while (n < 40 && (lat1 == 0 || lat4 == 0)) begin
      step();
      n++;
      if (lat1 == 0 && out_valid1) lat1 = n;
      if (lat4 == 0 && out_valid4) lat4 = n;
    end
    check({tag, "_lat1"}, lat1, 17);
    check({tag, "_lat4"}, lat4, 5);
    check({tag, "_data1"}, pack(state_out1), exp);
    check({tag, "_data4"}, pack(state_out4), exp);
    check({tag, "_last1"}, last_out1, l);
    check({tag, "_last4"}, last_out4, l);
    out_ready1 = 1'b1;
    out_ready4 = 1'b1;
    step();
    out_ready1 = 1'b0;
    out_ready4 = 1'b0;
    check({tag, "_idle_valid1"}, out_valid1, 1'b0);
  endtask

  initial begin
    int  n;
    int  lat;
    bit  seen;
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++)
        inv_sbox_tab[16*r+k] = SBOX_ROWS[r][127-8*k -: 8];

    reset      = 1'b0;
    in_valid   = 1'b0;
    out_ready1 = 1'b0;
    out_ready4 = 1'b0;
    load('0, '0, 1'b0);
    step();
    step();
    check("rst_out_valid1", out_valid1, 1'b0);
    check("rst_in_ready1", in_ready1, 1'b1);
    check("rst_state_out1", pack(state_out1), '0);
    check("rst_last_out1", last_out1, 1'b0);
    check("rst_out_valid4", out_valid4, 1'b0);
    reset = 1'b1;
    step();

    run_pair("t1_zero", '0, '0, 1'b0, {16{8'h52}});
    run_pair("t2_ff", {16{8'h63}}, {16{8'hFF}}, 1'b1, {16{8'hFF}});
    run_pair("t3_rows01", 128'h637C6363_77636363_63636363_63636363, '0, 1'b0,
             128'h00000000_02010000_00000000_00000000);
    run_pair("t3_rows23", 128'h63637C77_63636363_63636363_63636363, '0, 1'b0,
             128'h00000000_00000000_00000100_00000002);
    run_pair("key_bytes", {16{8'h63}}, 128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0,
             128'h00010203_04050607_08090A0B_0C0D0E0F);

    // Back-pressure hold, then back-to-back capture on the handshake edge
    load('0, '0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (n < 40 && !out_valid1) begin
      step();
      n++;
    end
    check("t4_first_lat", n, 17);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_hold_valid", out_valid1, 1'b1);
      check("t4_hold_in_ready", in_ready1, 1'b0);
      check("t4_hold_data", pack(state_out1), {16{8'h52}});
    end
    load({16{8'h63}}, {16{8'hFF}}, 1'b1);
    in_valid   = 1'b1;
    out_ready1 = 1'b1;
    #1;
    check("t4_pass_in_ready", in_ready1, 1'b1);
    step();
    in_valid   = 1'b0;
    out_ready1 = 1'b0;
    check("t4_after_hs_valid", out_valid1, 1'b0);
    lat = 1;
    while (lat < 40 && !out_valid1) begin
      step();
      lat++;
    end
    check("t4_second_lat", lat, 17);
    check("t4_second_data", pack(state_out1), {16{8'hFF}});
    check("t4_second_last", last_out1, 1'b1);
    out_ready1 = 1'b1;
    out_ready4 = 1'b1;
    step();
    out_ready1 = 1'b0;
    out_ready4 = 1'b0;

    // Reset in the middle of SUB discards the block
    load({16{8'h63}}, {16{8'hFF}}, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    step();
    check("t5_out_valid", out_valid1, 1'b0);
    check("t5_in_ready", in_ready1, 1'b1);
    check("t5_state_out", pack(state_out1), '0);
    check("t5_last_out", last_out1, 1'b0);
    reset      = 1'b1;
    out_ready1 = 1'b1;
    out_ready4 = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid1 || out_valid4) seen = 1'b1;
    end
    check("t5_block_dropped", seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
